// File: rtl/counter_scheduler_if.sv
// Request/grant bundle between the requesting blocks and counter_scheduler.
// The master side raises requests; the slave side (the scheduler) answers.
interface counter_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int BITS  = 8
);
  logic [N_REQ-1:0]      req;
  logic [N_REQ*BITS-1:0] duration;
  logic [N_REQ-1:0]      grant;
  logic [N_REQ-1:0]      done;
  logic                  busy;
  logic [BITS-1:0]       count;

  modport master (
    output req, duration,
    input  grant, done, busy, count
  );

  modport slave (
    input  req, duration,
    output grant, done, busy, count
  );
endinterface

// File: rtl/counter_scheduler.sv
// Round-robin time-sharing of one up-counter between N_REQ requesters.
// Each grant runs the counter 0..duration, then pulses done for one cycle.
module counter_scheduler #(
  parameter int N_REQ = 4,
  parameter int BITS  = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  counter_scheduler_if.slave  bus
);
  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [LW-1:0]    last, last_nxt, pick;
  logic [BITS-1:0]  dur_q, dur_nxt;
  logic [BITS-1:0]  count_q, count_nxt;
  logic [N_REQ-1:0] grant_q, grant_nxt;
  logic [N_REQ-1:0] done_q, done_nxt;
  logic             busy_q;

  // Scan from last+N down to last+1 so the nearest requester after last wins.
  function automatic logic [LW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [LW-1:0]    lst);
    logic [LW-1:0] p;
    int            idx;
    p = lst;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(lst) + k) % N_REQ;
      if (r[idx]) p = LW'(idx);
    end
    return p;
  endfunction

  always_comb pick = rr_pick(bus.req, last);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    dur_nxt   = dur_q;
    count_nxt = count_q;
    grant_nxt = '0;
    done_nxt  = '0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt       = RUN;
          grant_nxt[pick] = 1'b1;
          count_nxt       = '0;
          dur_nxt         = bus.duration[int'(pick)*BITS +: BITS];
          last_nxt        = pick;
        end
      end
      RUN: begin
        // The owner is always `last`; dropping its req aborts without done.
        if (!bus.req[last]) begin
          state_nxt = IDLE;
        end else if (count_q == dur_q) begin
          state_nxt      = DONE;
          done_nxt[last] = 1'b1;
        end else begin
          count_nxt       = count_q + 1'b1;
          grant_nxt[last] = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      last    <= LW'(N_REQ - 1);
      dur_q   <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      dur_q   <= dur_nxt;
      count_q <= count_nxt;
      grant_q <= grant_nxt;
      done_q  <= done_nxt;
      busy_q  <= (state_nxt != IDLE);
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench for counter_scheduler: stimulus queues expected output
// frames, a negedge monitor pops one frame per cycle with grant or done high.
module tb_counter_scheduler;
  localparam int N = 4;
  localparam int B = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  counter_scheduler_if #(.N_REQ(N), .BITS(B)) bus ();
  counter_scheduler #(.N_REQ(N), .BITS(B)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [N-1:0] g;
    logic [N-1:0] d;
    logic [B-1:0] c;
    int           gap;
  } frame_t;

  frame_t expq[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // gap = cycles since the previous output frame; 0 leaves it unchecked
  task automatic exp(input int g, input int d, input int c, input int gap);
    frame_t f;
    f.g = N'(g); f.d = N'(d); f.c = B'(c); f.gap = gap;
    expq.push_back(f);
  endtask

  function automatic logic [N*B-1:0] durs(input int d0, input int d1, input int d2, input int d3);
    return {B'(d3), B'(d2), B'(d1), B'(d0)};
  endfunction

  always @(negedge clock) begin
    frame_t f;
    cyc++;
    if (reset_n && (bus.grant != '0 || bus.done != '0)) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output grant=%b done=%b count=%0d required=none",
                 bus.grant, bus.done, bus.count);
      end else begin
        f = expq.pop_front();
        check("frame{grant,done,count}", 32'({bus.grant, bus.done, bus.count}),
              32'({f.g, f.d, f.c}));
        if (f.gap != 0) check("frame_gap", cyc - last_out, f.gap);
      end
      last_out = cyc;
    end
  end

  task automatic do_reset();
    bus.req      = '0;
    bus.duration = '0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_done",  32'(bus.done),  0);
    check("rst_busy",  32'(bus.busy),  0);
    check("rst_count", 32'(bus.count), 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Wait for n done pulses, dropping all requests on the last one.
  task automatic run_dones(input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clock);
      if (bus.done != '0) begin
        seen++;
        if (seen == n) bus.req = '0;
      end
    end
    check("dones_seen", seen, n);
    repeat (3) @(negedge clock);
    check("idle_busy", 32'(bus.busy), 0);
    check("drained", expq.size(), 0);
  endtask

  initial begin
    int nb;
    int found;
    reset_n      = 1'b1;
    bus.req      = '0;
    bus.duration = '0;
    #1 reset_n = 1'b0;
    #1;
    check("init_grant", 32'(bus.grant), 0);
    check("init_busy",  32'(bus.busy),  0);
    check("init_count", 32'(bus.count), 0);

    // Single requester, duration 3
    do_reset();
    bus.duration = durs(3, 0, 0, 0);
    bus.req      = 4'b0001;
    exp(1, 0, 0, 0); exp(1, 0, 1, 1); exp(1, 0, 2, 1); exp(1, 0, 3, 1); exp(0, 1, 3, 1);
    @(negedge clock);
    check("t1_latency_grant", 32'(bus.grant), 1);
    nb = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.done != '0) bus.req = '0;
      if (bus.busy) nb++;
      else break;
    end
    check("t1_busy_cycles", nb, 5);
    repeat (2) @(negedge clock);
    check("t1_drained", expq.size(), 0);

    // Round robin, all four requesting, zero durations
    do_reset();
    bus.duration = durs(0, 0, 0, 0);
    bus.req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp(1 << (k % 4), 0, 0, (k == 0) ? 0 : 2);
      exp(0, 1 << (k % 4), 0, 1);
    end
    run_dones(5, 40);

    // Fairness: requester 0 re-requests but must alternate with 1
    do_reset();
    bus.duration = durs(2, 2, 0, 0);
    bus.req      = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      exp(1 << (k % 2), 0, 0, (k == 0) ? 0 : 2);
      exp(1 << (k % 2), 0, 1, 1);
      exp(1 << (k % 2), 0, 2, 1);
      exp(0, 1 << (k % 2), 2, 1);
    end
    run_dones(4, 60);

    // Abort requester 2 at count 4
    do_reset();
    bus.duration = durs(0, 0, 10, 0);
    bus.req      = 4'b0100;
    exp(4, 0, 0, 0);
    for (int c = 1; c <= 4; c++) exp(4, 0, c, 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.grant == 4'b0100 && bus.count == 4'd4) begin
        found = 1;
        break;
      end
    end
    check("abort_reached", found, 1);
    bus.req = '0;
    @(negedge clock);
    check("abort_grant", 32'(bus.grant), 0);
    check("abort_done",  32'(bus.done),  0);
    check("abort_busy",  32'(bus.busy),  0);
    check("abort_count", 32'(bus.count), 4);
    repeat (3) @(negedge clock);
    check("abort_count_hold", 32'(bus.count), 4);
    bus.duration = durs(0, 0, 0, 0);
    bus.req      = 4'b0001;
    exp(1, 0, 0, 0); exp(0, 1, 0, 1);
    run_dones(1, 10);

    // Full range duration 15, with duration changed mid-run
    do_reset();
    bus.duration = durs(15, 0, 0, 0);
    bus.req      = 4'b0001;
    exp(1, 0, 0, 0);
    for (int c = 1; c <= 15; c++) exp(1, 0, c, 1);
    exp(0, 1, 15, 1);
    repeat (3) @(negedge clock);
    bus.duration = durs(1, 0, 0, 0);
    run_dones(1, 40);

    // Asynchronous reset mid-run at count 5
    do_reset();
    bus.duration = durs(10, 0, 0, 0);
    bus.req      = 4'b0001;
    exp(1, 0, 0, 0);
    for (int c = 1; c <= 5; c++) exp(1, 0, c, 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.grant == 4'b0001 && bus.count == 4'd5) begin
        found = 1;
        break;
      end
    end
    check("arst_reached", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_grant", 32'(bus.grant), 0);
    check("arst_done",  32'(bus.done),  0);
    check("arst_busy",  32'(bus.busy),  0);
    check("arst_count", 32'(bus.count), 0);
    check("arst_drained", expq.size(), 0);
    bus.req      = 4'b1001;
    bus.duration = durs(1, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    exp(1, 0, 0, 0); exp(1, 0, 1, 1); exp(0, 1, 1, 1);
    @(negedge clock);
    check("rel_first_grant", 32'(bus.grant), 1);
    run_dones(1, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
